inv_tree_monitor: RTL and testbench

- Downstream capture stage for the inverter fanout tree; samples its four leaf outputs (dout1..dout4) in a clocked measurement window.
- Synchronises each leaf, counts transitions per leaf, timestamps the first edge per leaf, then reports counts, a count-mismatch flag and the first-edge skew.
- Purpose: on-silicon/post-layout check that all tree branches see identical pulse trains (no swallowed or extra glitches) and bounded arrival skew.

---
 rtl/inv_tree_mon_pkg.sv | 12 +
 rtl/inv_tree_mon_leaf.sv | 70 +++++++
 rtl/inv_tree_monitor.sv | 128 ++++++++++++
 tb/tb_inv_tree_monitor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inv_tree_mon_pkg.sv
// inv_tree_mon_pkg: shared constants and FSM state encoding for the fanout-tree monitor
package inv_tree_mon_pkg;

    localparam int NUM_LEAVES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/inv_tree_mon_leaf.sv
// inv_tree_mon_leaf: per-leaf synchroniser, edge detector, saturating counter and first-edge timestamp
module inv_tree_mon_leaf
    import inv_tree_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIN_W-1:0] elapsed_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic [WIN_W-1:0] ts_nxt_o,
    output logic             seen_nxt_o,
    output logic             sat_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIN_W-1:0]       ts_q, ts_d;
    logic                   seen_q, seen_d;
    logic                   sat_q, sat_d;
    logic                   hit, full;

    // synchroniser and previous sample free-run so entering RUN never creates a false edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        hit    = en_i & (sync_q[SYNC_STAGES-1] ^ prev_q);
        full   = &cnt_q;
        cnt_d  = clr_i ? '0 : (hit & ~full) ? cnt_q + CNT_W'(1) : cnt_q;
        sat_d  = clr_i ? 1'b0 : sat_q | (hit & full);
        seen_d = clr_i ? 1'b0 : seen_q | hit;
        ts_d   = clr_i ? '0 : (hit & ~seen_q) ? elapsed_i : ts_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            ts_q   <= '0;
            seen_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ts_q   <= ts_d;
            seen_q <= seen_d;
            sat_q  <= sat_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_nxt_o  = cnt_d;
    assign ts_nxt_o   = ts_d;
    assign seen_nxt_o = seen_d;
    assign sat_o      = sat_q;

endmodule

// File: rtl/inv_tree_monitor.sv
// inv_tree_monitor: windowed transition counting, mismatch and first-edge skew check over four tree leaves
module inv_tree_monitor
    import inv_tree_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [WIN_W-1:0]            win_len_i,
    input  logic [NUM_LEAVES-1:0]       dout_i,
    output logic                        busy_o,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [NUM_LEAVES*CNT_W-1:0] cnt_flat_o,
    output logic                        mismatch_o,
    output logic [WIN_W-1:0]            skew_o,
    output logic                        sat_o
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]            state_q, state_d;
    logic [WIN_W-1:0]      win_q, win_d;
    logic [WIN_W-1:0]      el_q, el_d;
    logic                  mis_q, mis_d;
    logic [WIN_W-1:0]      skew_q, skew_d;
    logic                  clr, en;
    logic                  mis_nxt;
    logic [WIN_W-1:0]      skew_nxt, mx, mn;
    logic [CNT_W-1:0]      cnt_w   [NUM_LEAVES];
    logic [CNT_W-1:0]      cnt_nxt [NUM_LEAVES];
    logic [WIN_W-1:0]      ts_nxt  [NUM_LEAVES];
    logic [NUM_LEAVES-1:0] seen_nxt, sat_v;

    for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_leaf
        inv_tree_mon_leaf #(
            .CNT_W      (CNT_W),
            .WIN_W      (WIN_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_leaf (
            .clk       (clk),
            .rst       (rst),
            .din_i     (dout_i[i]),
            .clr_i     (clr),
            .en_i      (en),
            .elapsed_i (el_q),
            .cnt_o     (cnt_w[i]),
            .cnt_nxt_o (cnt_nxt[i]),
            .ts_nxt_o  (ts_nxt[i]),
            .seen_nxt_o(seen_nxt[i]),
            .sat_o     (sat_v[i])
        );
        assign cnt_flat_o[i*CNT_W +: CNT_W] = cnt_w[i];
    end

    // reduction uses next-state leaf values so edges in the final RUN cycle are included
    always_comb begin
        mx      = '0;
        mn      = '1;
        mis_nxt = 1'b0;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            mis_nxt = mis_nxt | (cnt_nxt[k] != cnt_nxt[0]);
            mx      = (seen_nxt[k] && ts_nxt[k] > mx) ? ts_nxt[k] : mx;
            mn      = (seen_nxt[k] && ts_nxt[k] < mn) ? ts_nxt[k] : mn;
        end
        skew_nxt = (mx >= mn) ? mx - mn : '0;
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        el_d    = el_q;
        mis_d   = mis_q;
        skew_d  = skew_q;
        clr     = 1'b0;
        en      = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                clr     = 1'b1;
                win_d   = win_len_i;
                el_d    = '0;
                mis_d   = 1'b0;
                skew_d  = '0;
                state_d = (win_len_i == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                en    = 1'b1;
                el_d  = el_q + WIN_W'(1);
                win_d = win_q - WIN_W'(1);
                if (win_q == WIN_W'(1)) begin
                    state_d = S_DONE;
                    mis_d   = mis_nxt;
                    skew_d  = skew_nxt;
                end
            end
            S_DONE: state_d = res_ready_i ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            el_q    <= '0;
            mis_q   <= 1'b0;
            skew_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            el_q    <= el_d;
            mis_q   <= mis_d;
            skew_q  <= skew_d;
        end
    end

    assign busy_o      = (state_q == S_RUN);
    assign res_valid_o = (state_q == S_DONE);
    assign mismatch_o  = mis_q;
    assign skew_o      = skew_q;
    assign sat_o       = |sat_v;

endmodule

// File: tb/tb_inv_tree_monitor.sv
// tb_inv_tree_monitor: randomized and directed windows checked by a scoreboard against a waveform-level model
module tb_inv_tree_monitor;

    localparam int CNT_W = 4;
    localparam int WIN_W = 16;
    localparam int MAXW  = 128;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4*CNT_W-1:0] cnt;
        logic               mis;
        logic [WIN_W-1:0]   skew;
        logic               sat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [WIN_W-1:0]   win_len = '0;
    logic [3:0]         dout = '0;
    logic               res_ready = 1'b0;
    logic               busy, res_valid, mismatch, sat;
    logic [4*CNT_W-1:0] cnt_flat;
    logic [WIN_W-1:0]   skew;

    logic [3:0] wave [MAXW];
    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    inv_tree_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .win_len_i  (win_len),
        .dout_i     (dout),
        .busy_o     (busy),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .cnt_flat_o (cnt_flat),
        .mismatch_o (mismatch),
        .skew_o     (skew),
        .sat_o      (sat)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // wave[c] is the leaf vector seen by window cycle c; an edge counts in cycle c when it differs from the previous value
    function automatic exp_t model(input int wl, input logic [3:0] base);
        exp_t e;
        int n[4];
        int fst[4];
        int mx, mn, ns;
        logic [3:0] prev;
        e    = '0;
        prev = base;
        mx   = 0;
        mn   = 0;
        ns   = 0;
        for (int i = 0; i < 4; i++) begin
            n[i]   = 0;
            fst[i] = -1;
        end
        for (int c = 0; c < wl; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (wave[c][i] != prev[i]) begin
                    if (n[i] == CMAX) e.sat = 1'b1;
                    else n[i]++;
                    if (fst[i] < 0) fst[i] = c;
                end
            end
            prev = wave[c];
        end
        for (int i = 0; i < 4; i++) begin
            e.cnt[i*CNT_W +: CNT_W] = CNT_W'(n[i]);
            if (n[i] != n[0]) e.mis = 1'b1;
            if (fst[i] >= 0) begin
                if (ns == 0 || fst[i] > mx) mx = fst[i];
                if (ns == 0 || fst[i] < mn) mn = fst[i];
                ns++;
            end
        end
        e.skew = (ns >= 2) ? WIN_W'(mx - mn) : '0;
        return e;
    endfunction

    task automatic set_wave();
        for (int c = 0; c < MAXW; c++) wave[c] = dout;
    endtask

    task automatic pulse(input int leaf, input int a, input int b);
        for (int c = a; c <= b; c++) wave[c][leaf] = ~wave[c][leaf];
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_cnt"}, 64'(cnt_flat), 0);
        cmp({tag, "_mis"}, 64'(mismatch), 0);
        cmp({tag, "_skew"}, 64'(skew), 0);
        cmp({tag, "_sat"}, 64'(sat), 0);
        cmp({tag, "_busy"}, 64'(busy), 0);
        cmp({tag, "_valid"}, 64'(res_valid), 0);
    endtask

    // start is accepted at the posedge of j==2; wave[j] is driven after posedge j so it is counted in window cycle j
    task automatic run_window(input int wl, input int rdy_dly, input int abort_c, input bit start_on_ack);
        logic [3:0] base;
        exp_t       e;
        bit         aborted;
        base    = dout;
        aborted = 1'b0;
        win_len = WIN_W'(wl);
        e       = model(wl, base);
        if (abort_c < 0) exp_q.push_back(e);
        for (int j = 0; j < wl + 3; j++) begin
            @(posedge clk);
            #1;
            dout  = wave[j];
            start = (j == 1) || (j == 4 && wl > 4);
            if (j == 2) begin
                cmp("busy_after_start", 64'(busy), 64'(wl != 0));
                cmp("valid_after_start", 64'(res_valid), 64'(wl == 0));
            end
            if (wl > 0 && j == wl + 1) cmp("valid_last_run", 64'(res_valid), 0);
            if (j == wl + 2) cmp("valid_done", 64'(res_valid), 1);
            if (abort_c >= 0 && j == abort_c + 2) begin
                rst = 1'b1;
                #1;
                check_zero("abort");
                #2;
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            repeat (rdy_dly) @(posedge clk);
            @(posedge clk);
            #1;
            res_ready = 1'b1;
            start     = start_on_ack;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            start     = 1'b0;
            cmp("idle_valid", 64'(res_valid), 0);
            cmp("idle_busy", 64'(busy), 0);
            cmp("idle_hold_cnt", 64'(cnt_flat), 64'(e.cnt));
            cmp("idle_hold_skew", 64'(skew), 64'(e.skew));
        end
        repeat (5) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (exp_q.size() == 0) begin
                cmp("unexpected_result", 64'(res_valid), 0);
            end else begin
                cmp("res_cnt", 64'(cnt_flat), 64'(exp_q[0].cnt));
                cmp("res_mismatch", 64'(mismatch), 64'(exp_q[0].mis));
                cmp("res_skew", 64'(skew), 64'(exp_q[0].skew));
                cmp("res_sat", 64'(sat), 64'(exp_q[0].sat));
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        repeat (5) @(posedge clk);

        set_wave();
        run_window(0, 0, -1, 1'b0);

        set_wave();
        for (int i = 0; i < 4; i++) pulse(i, 5, 14);
        run_window(50, 2, -1, 1'b0);

        set_wave();
        for (int i = 0; i < 3; i++) pulse(i, 5, 14);
        pulse(3, 8, 17);
        run_window(50, 0, -1, 1'b1);

        set_wave();
        for (int i = 0; i < 4; i++) pulse(i, 5, 14);
        pulse(1, 40, 40);
        run_window(100, 1, -1, 1'b0);

        set_wave();
        for (int k = 0; k < 10; k++) pulse(0, 1 + 4 * k, 2 + 4 * k);
        run_window(60, 10, -1, 1'b0);

        set_wave();
        for (int k = 0; k < 3; k++) pulse(0, 1 + 4 * k, 2 + 4 * k);
        run_window(40, 0, 11, 1'b0);
        set_wave();
        for (int i = 0; i < 4; i++) pulse(i, 3, 8);
        run_window(30, 0, -1, 1'b0);

        set_wave();
        pulse(2, 0, 0);
        pulse(0, 9, 9);
        run_window(10, 0, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int wl;
            int p;
            wl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
            p  = int'($urandom_range(1, 4));
            wave[0] = dout ^ (($urandom_range(0, p) == 0) ? 4'($urandom) : 4'b0);
            for (int c = 1; c < wl + 3; c++)
                wave[c] = wave[c-1] ^ (($urandom_range(0, p) == 0) ? 4'($urandom) : 4'b0);
            run_window(wl, int'($urandom_range(0, 4)), -1, 1'($urandom));
        end

        cmp("queue_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
